// File: rtl/vote_input_conditioner.sv
// vote_input_conditioner
//   Turns four raw candidate buttons and the mode switch into clean,
//   single-cycle, mutually exclusive vote strobes for votingMachine.
//   Path per button: 2-flop synchronizer -> hold-time qualifier -> press/release FSM.
// Ports:
//   clk, reset               rising-edge clock, async active-high reset
//   button1..button4, mode   raw asynchronous inputs
//   press_onehot[3:0]        one-cycle strobe, bit n-1 = buttonN accepted
//   press_id[1:0]            encoded id of the last accepted button (held)
//   press_valid              one-cycle strobe coincident with press_onehot
//   multi_press_err          one-cycle strobe on a rejected multi-button press
//   mode_sync                synchronized mode switch
//   busy                     high whenever the FSM is not IDLE

// Two-flop synchronizer for one asynchronous bit.
module vic_sync (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);
   logic meta;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

module vote_input_conditioner #(
   parameter int HOLD_CYCLES = 10,
   parameter int CNT_W       = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       button1,
   input  logic       button2,
   input  logic       button3,
   input  logic       button4,
   input  logic       mode,
   output logic [3:0] press_onehot,
   output logic [1:0] press_id,
   output logic       press_valid,
   output logic       multi_press_err,
   output logic       mode_sync,
   output logic       busy
);
   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] QUALIFY  = 2'd1;
   localparam logic [1:0] WAIT_REL = 2'd2;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

   logic [4:0] raw, syn;
   logic [3:0] b_s;
   logic [2:0] ones;
   logic [1:0] idx;
   logic [1:0] state;
   logic [1:0] cand;
   logic [3:0] cand_oh;
   logic [CNT_W-1:0] cnt;
   logic       mode_prev;
   logic       mode_tgl;

   assign raw = {mode, button4, button3, button2, button1};

   // One synchronizer per raw input: lanes 0..3 buttons, lane 4 mode.
   for (genvar i = 0; i < 5; i++) begin : g_sync
      vic_sync u_sync (.clk(clk), .reset(reset), .d(raw[i]), .q(syn[i]));
   end

   assign b_s       = syn[3:0];
   assign mode_sync = syn[4];

   assign ones = {2'b0, b_s[0]} + {2'b0, b_s[1]} + {2'b0, b_s[2]} + {2'b0, b_s[3]};

   // Index encoder, only meaningful when exactly one bit is set.
   always_comb begin
      idx = 2'd0;
      for (int i = 0; i < 4; i++)
         if (b_s[i]) idx = 2'(i);
   end

   assign cand_oh  = 4'b0001 << cand;
   assign mode_tgl = mode_sync ^ mode_prev;
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         cand            <= 2'd0;
         cnt             <= '0;
         mode_prev       <= 1'b0;
         press_onehot    <= 4'b0;
         press_id        <= 2'd0;
         press_valid     <= 1'b0;
         multi_press_err <= 1'b0;
      end else begin
         mode_prev       <= mode_sync;
         press_onehot    <= 4'b0;
         press_valid     <= 1'b0;
         multi_press_err <= 1'b0;
         case (state)
            IDLE: begin
               if (ones == 3'd1) begin
                  state <= QUALIFY;
                  cand  <= idx;
                  cnt   <= CNT_W'(1);
               end else if (ones >= 3'd2) begin
                  multi_press_err <= 1'b1;
                  state           <= WAIT_REL;
               end
            end
            QUALIFY: begin
               // A mode change mid-press makes the press ambiguous: drop it silently.
               if (mode_tgl) begin
                  state <= WAIT_REL;
               end else if (b_s == cand_oh) begin
                  if (cnt == LAST) begin
                     press_valid  <= 1'b1;
                     press_onehot <= cand_oh;
                     press_id     <= cand;
                     state        <= WAIT_REL;
                  end else if (cnt < LAST) begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end else if (b_s == 4'b0) begin
                  state <= IDLE;
               end else begin
                  multi_press_err <= 1'b1;
                  state           <= WAIT_REL;
               end
            end
            WAIT_REL: begin
               if (b_s == 4'b0) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_vote_input_conditioner.sv
module tb_vote_input_conditioner;
   logic       clk = 1'b0;
   logic       reset;
   logic       button1, button2, button3, button4, mode;
   logic [3:0] press_onehot;
   logic [1:0] press_id;
   logic       press_valid, multi_press_err, mode_sync, busy;

   vote_input_conditioner #(.HOLD_CYCLES(10), .CNT_W(8)) dut (
      .clk(clk), .reset(reset),
      .button1(button1), .button2(button2), .button3(button3), .button4(button4),
      .mode(mode),
      .press_onehot(press_onehot), .press_id(press_id), .press_valid(press_valid),
      .multi_press_err(multi_press_err), .mode_sync(mode_sync), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic       err;
      logic [3:0] oh;
      logic [1:0] id;
      int         at;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every strobe must match the oldest expected event.
   always @(negedge clk) begin
      if (!reset && (press_valid || multi_press_err)) begin
         exp_t e;
         chk("strobe_exclusive", int'(press_valid & multi_press_err), 0);
         if (sb.size() == 0) begin
            chk("unexpected_strobe", {press_valid, multi_press_err}, 0);
         end else begin
            e = sb.pop_front();
            chk("sb_err",   int'(multi_press_err), int'(e.err));
            chk("sb_valid", int'(press_valid), int'(!e.err));
            chk("sb_cycle", cyc, e.at);
            if (!e.err) begin
               chk("sb_onehot", int'(press_onehot), int'(e.oh));
               chk("sb_id",     int'(press_id),     int'(e.id));
            end
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drive button (1..4) at a negedge; cyc then equals the edge count P.
   // First sampling edge is P+1, so an accept appears with cyc == P+12,
   // and a multi-press error with cyc == P+3.
   task automatic set_btn(input int n, input logic v);
      case (n)
         1: button1 = v;
         2: button2 = v;
         3: button3 = v;
         default: button4 = v;
      endcase
   endtask

   task automatic expect_vote(input int p, input int n);
      exp_t e;
      e.err = 1'b0;
      e.oh  = 4'b0001 << (n - 1);
      e.id  = 2'(n - 1);
      e.at  = p + 12;
      sb.push_back(e);
   endtask

   initial begin
      int p;
      exp_t e;
      reset = 1'b1;
      {button1, button2, button3, button4, mode} = '0;

      // 1: reset state
      #50;
      chk("rst_outputs", {press_onehot, press_id, press_valid, multi_press_err, mode_sync, busy}, 0);
      #50;
      @(negedge clk);
      reset = 1'b0;
      cycles(2);
      chk("post_rst_outputs", {press_onehot, press_id, press_valid, multi_press_err, mode_sync, busy}, 0);

      // 2: one-cycle glitch on button1
      button1 = 1'b1;
      cycles(1);
      button1 = 1'b0;
      cycles(4);
      chk("glitch_busy", int'(busy), 0);

      // 3: button1 held 20 cycles
      cycles(2);
      p = cyc;
      expect_vote(p, 1);
      button1 = 1'b1;
      cycles(8);
      chk("qualify_busy", int'(busy), 1);
      cycles(12);
      button1 = 1'b0;
      chk("press_id_held", int'(press_id), 0);
      cycles(5);
      chk("after_b1_busy", int'(busy), 0);

      // 4: button2 and button3 together
      p = cyc;
      e.err = 1'b1; e.oh = 4'b0; e.id = 2'd0; e.at = p + 3;
      sb.push_back(e);
      button2 = 1'b1;
      button3 = 1'b1;
      cycles(20);
      chk("multi_busy_held", int'(busy), 1);
      button2 = 1'b0;
      cycles(5);
      chk("multi_busy_one_left", int'(busy), 1);
      button3 = 1'b0;
      cycles(5);
      chk("multi_busy_released", int'(busy), 0);

      // 5: mode change during QUALIFY aborts silently
      p = cyc;
      button4 = 1'b1;
      cycles(7);               // QUALIFY entered at edge p+3
      chk("mode_qualify_busy", int'(busy), 1);
      mode = 1'b1;
      cycles(1);
      chk("mode_sync_1cyc", int'(mode_sync), 0);
      cycles(1);
      chk("mode_sync_2cyc", int'(mode_sync), 1);
      cycles(15);
      chk("mode_abort_busy", int'(busy), 1);
      button4 = 1'b0;
      cycles(5);
      chk("mode_abort_idle", int'(busy), 0);
      p = cyc;
      expect_vote(p, 4);
      button4 = 1'b1;
      cycles(20);
      button4 = 1'b0;
      cycles(5);
      chk("b4_press_id", int'(press_id), 3);

      // 6: button3 8 cycles, released 1, held 20: only the second rise counts
      p = cyc;
      button3 = 1'b1;
      cycles(8);
      button3 = 1'b0;
      cycles(1);
      p = cyc;
      expect_vote(p, 3);
      button3 = 1'b1;
      cycles(20);
      button3 = 1'b0;
      cycles(6);
      chk("b3_press_id", int'(press_id), 2);

      // Reset mid-QUALIFY suppresses the pending vote
      button2 = 1'b1;
      cycles(8);
      reset = 1'b1;
      cycles(1);
      chk("rst_mid_busy", int'(busy), 0);
      reset = 1'b0;
      button2 = 1'b0;
      cycles(20);
      chk("rst_mid_idle", int'(busy), 0);

      chk("sb_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
